// File: rtl/pic_ram_writer_if.sv
// Pixel stream (s_*) and display-RAM write port (wr_*) for pic_ram_writer.
// The slave modport is the writer's view; master is the source/RAM side.
interface pic_ram_writer_if #(
  parameter int unsigned ADDR_W = 17,
  parameter int unsigned DATA_W = 24
);
  logic [DATA_W-1:0] s_data;
  logic              s_valid;
  logic              s_sof;
  logic              s_eol;
  logic              s_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  modport master (
    output s_data, s_valid, s_sof, s_eol,
    input  s_ready, wr_en, wr_addr, wr_data
  );

  modport slave (
    input  s_data, s_valid, s_sof, s_eol,
    output s_ready, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/pic_ram_writer.sv
// Captures one raster-order frame from the pixel stream into the display RAM.
// Optional macro PIC_TEST_PATTERN_EN adds i_tp_mode for an internal 8-bar colour pattern.
module pic_ram_writer #(
  parameter int unsigned IMG_W  = 480,
  parameter int unsigned IMG_H  = 270,
  parameter int unsigned ADDR_W = 17,
  parameter int unsigned DATA_W = 24
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic                  i_frame_sw_ram,
`ifdef PIC_TEST_PATTERN_EN
  input  logic                  i_tp_mode,
`endif
  pic_ram_writer_if.slave       bus,
  output logic                  o_pic_done,
  output logic                  o_busy,
  output logic                  o_err_sync
);
  localparam int unsigned XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [XW-1:0]     XLast    = XW'(IMG_W - 1);
  localparam logic [YW-1:0]     YLast    = YW'(IMG_H - 1);
  localparam logic [ADDR_W-1:0] LineStep = ADDR_W'(IMG_W);

  typedef enum logic [1:0] {StIdle, StWaitSof, StWrite, StDone} state_e;

  state_e            r_state;
  logic              r_start_pend, r_fin, r_s_ready, r_wr_en;
  logic              r_pic_done, r_busy, r_err_sync;
  logic [ADDR_W-1:0] r_wr_addr, r_base;
  logic [DATA_W-1:0] r_wr_data;
  logic [XW-1:0]     r_x;
  logic [YW-1:0]     r_y;

  logic              w_beat, w_take, w_x_last, w_y_last, w_eol_bad, w_launch;
  logic              w_tp, w_tp_req;
  logic [DATA_W-1:0] w_px;

  assign w_beat    = bus.s_valid & r_s_ready;
  assign w_x_last  = (r_x == XLast);
  assign w_y_last  = (r_y == YLast);
  assign w_eol_bad = (bus.s_eol != w_x_last);
  assign w_launch  = ((r_state == StIdle) || (r_state == StDone)) && r_start_pend &&
                     !i_frame_sw_ram;

`ifdef PIC_TEST_PATTERN_EN
  localparam int unsigned BarW  = IMG_W / 8;
  localparam int unsigned CW    = (BarW > 1) ? $clog2(BarW) : 1;
  localparam logic [CW-1:0] ColLast = CW'(BarW - 1);

  logic          r_tp;
  logic [CW-1:0] r_col;
  logic [2:0]    r_bar;

  function automatic logic [23:0] bar_rgb(input logic [2:0] idx);
    case (idx)
      3'd0:    bar_rgb = 24'hFFFFFF;
      3'd1:    bar_rgb = 24'hFFFF00;
      3'd2:    bar_rgb = 24'h00FFFF;
      3'd3:    bar_rgb = 24'h00FF00;
      3'd4:    bar_rgb = 24'hFF00FF;
      3'd5:    bar_rgb = 24'hFF0000;
      3'd6:    bar_rgb = 24'h0000FF;
      default: bar_rgb = 24'h000000;
    endcase
  endfunction

  // Bar position tracks r_x without a divider: column within bar plus bar index.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_tp  <= 1'b0;
      r_col <= '0;
      r_bar <= '0;
    end else if (w_launch) begin
      r_tp  <= i_tp_mode;
      r_col <= '0;
      r_bar <= '0;
    end else if (r_tp && (r_state == StWrite)) begin
      if (w_x_last) begin
        r_col <= '0;
        r_bar <= '0;
      end else if (r_col == ColLast) begin
        r_col <= '0;
        r_bar <= r_bar + 3'd1;
      end else begin
        r_col <= r_col + CW'(1);
      end
    end
  end

  assign w_tp     = r_tp;
  assign w_tp_req = i_tp_mode;
  assign w_px     = w_tp ? DATA_W'(bar_rgb(r_bar)) : bus.s_data;
`else
  assign w_tp     = 1'b0;
  assign w_tp_req = 1'b0;
  assign w_px     = bus.s_data;
`endif

  assign w_take = w_tp | w_beat;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= StIdle;
      r_start_pend <= 1'b0;
      r_fin        <= 1'b0;
      r_s_ready    <= 1'b0;
      r_wr_en      <= 1'b0;
      r_pic_done   <= 1'b0;
      r_busy       <= 1'b0;
      r_err_sync   <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
      r_base       <= '0;
      r_x          <= '0;
      r_y          <= '0;
    end else begin
      r_wr_en <= 1'b0;
      r_fin   <= 1'b0;
      // pic_done lags the final write strobe by one cycle
      if (r_fin) r_pic_done <= 1'b1;
      case (r_state)
        StIdle, StDone: begin
          if (w_launch) begin
            r_start_pend <= 1'b0;
            r_pic_done   <= 1'b0;
            r_err_sync   <= 1'b0;
            r_busy       <= 1'b1;
            r_x          <= '0;
            r_y          <= '0;
            r_base       <= '0;
            if (w_tp_req) begin
              r_state   <= StWrite;
              r_s_ready <= 1'b0;
            end else begin
              r_state   <= StWaitSof;
              r_s_ready <= 1'b1;
            end
          end else if (i_start) begin
            r_start_pend <= 1'b1;
          end
        end
        StWaitSof: begin
          if (w_beat && bus.s_sof) begin
            r_wr_en   <= 1'b1;
            r_wr_addr <= '0;
            r_wr_data <= bus.s_data;
            r_x       <= XW'(1);
            r_y       <= '0;
            r_base    <= '0;
            r_state   <= StWrite;
          end
        end
        StWrite: begin
          if (w_take) begin
            if (!w_tp && bus.s_sof) begin
              // Mid-frame SOF restarts the frame at pixel (0,0)
              r_err_sync <= 1'b1;
              r_wr_en    <= 1'b1;
              r_wr_addr  <= '0;
              r_wr_data  <= bus.s_data;
              r_x        <= XW'(1);
              r_y        <= '0;
              r_base     <= '0;
            end else if (!w_tp && w_eol_bad) begin
              r_err_sync <= 1'b1;
              r_x        <= '0;
              r_y        <= '0;
              r_base     <= '0;
              r_state    <= StWaitSof;
            end else begin
              r_wr_en   <= 1'b1;
              r_wr_addr <= r_base + ADDR_W'(r_x);
              r_wr_data <= w_px;
              if (w_x_last) begin
                r_x <= '0;
                if (w_y_last) begin
                  r_state   <= StDone;
                  r_s_ready <= 1'b0;
                  r_busy    <= 1'b0;
                  r_fin     <= 1'b1;
                end else begin
                  r_y    <= r_y + YW'(1);
                  r_base <= r_base + LineStep;
                end
              end else begin
                r_x <= r_x + XW'(1);
              end
            end
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign bus.s_ready = r_s_ready;
  assign bus.wr_en   = r_wr_en;
  assign bus.wr_addr = r_wr_addr;
  assign bus.wr_data = r_wr_data;
  assign o_pic_done  = r_pic_done;
  assign o_busy      = r_busy;
  assign o_err_sync  = r_err_sync;
endmodule

// File: tb/tb_pic_ram_writer.sv
// Randomized bench for pic_ram_writer on a reduced 16x6 frame; a linear pixel-index
// reference model predicts every write, handshake level and status flag cycle by cycle.
module tb_pic_ram_writer;
  localparam int unsigned W  = 16;
  localparam int unsigned H  = 6;
  localparam int unsigned N  = W * H;
  localparam int unsigned AW = 17;
  localparam int unsigned DW = 24;

  localparam int MIdle  = 0;
  localparam int MWait  = 1;
  localparam int MWrite = 2;
  localparam int MDone  = 3;

  logic clk = 1'b0;
  logic rst, start, fsr;
  logic pic_done, busy, err_sync;

  always #5 clk = ~clk;

  pic_ram_writer_if #(.ADDR_W(AW), .DATA_W(DW)) u_bus ();

  pic_ram_writer #(
    .IMG_W (W),
    .IMG_H (H),
    .ADDR_W(AW),
    .DATA_W(DW)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_start       (start),
    .i_frame_sw_ram(fsr),
`ifdef PIC_TEST_PATTERN_EN
    .i_tp_mode     (1'b0),
`endif
    .bus           (u_bus),
    .o_pic_done    (pic_done),
    .o_busy        (busy),
    .o_err_sync    (err_sync)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: frame position is a single linear pixel index.
  int m_mode, m_p;
  bit m_pend, m_pd, m_pd_pend, m_err;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = MIdle; m_p = 0; m_pend = 0; m_pd = 0; m_pd_pend = 0; m_err = 0;
  endtask

  // One clock: check current outputs, predict next edge, advance, check write port.
  task automatic tick();
    bit exp_wr, new_pd, acc, rdy;
    int exp_addr;
    logic [DW-1:0] exp_data;
    rdy = (m_mode == MWait) || (m_mode == MWrite);
    check_eq("s_ready", u_bus.s_ready, rdy);
    check_eq("busy", busy, rdy);
    check_eq("pic_done", pic_done, m_pd);
    check_eq("err_sync", err_sync, m_err);
    exp_wr = 0; exp_addr = 0; exp_data = u_bus.s_data;
    if (rst) begin
      model_reset();
    end else begin
      new_pd = m_pd_pend ? 1'b1 : m_pd;
      m_pd_pend = 0;
      acc = u_bus.s_valid && rdy;
      case (m_mode)
        MIdle, MDone: begin
          if (m_pend && !fsr) begin
            m_mode = MWait; m_pend = 0; new_pd = 0; m_err = 0; m_p = 0;
          end else if (start) begin
            m_pend = 1;
          end
        end
        MWait: if (acc && u_bus.s_sof) begin
          exp_wr = 1; exp_addr = 0; m_p = 1; m_mode = MWrite;
        end
        MWrite: if (acc) begin
          if (u_bus.s_sof) begin
            m_err = 1; exp_wr = 1; exp_addr = 0; m_p = 1;
          end else if (u_bus.s_eol != ((m_p % W) == W - 1)) begin
            m_err = 1; m_mode = MWait; m_p = 0;
          end else begin
            exp_wr = 1; exp_addr = m_p; m_p++;
            if (m_p == N) begin
              m_mode = MDone; m_pd_pend = 1;
            end
          end
        end
        default: ;
      endcase
      m_pd = new_pd;
    end
    @(posedge clk);
    #1;
    check_eq("wr_en", u_bus.wr_en, exp_wr);
    if (exp_wr) begin
      check_eq("wr_addr", u_bus.wr_addr, exp_addr);
      check_eq("wr_data", u_bus.wr_data, exp_data);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      u_bus.s_valid = 0;
      u_bus.s_sof   = 1'($urandom);
      u_bus.s_eol   = 1'($urandom);
      u_bus.s_data  = DW'($urandom);
      tick();
    end
  endtask

  task automatic send_beat(input bit sof, input bit eol, input int gap_max);
    idle(int'($urandom_range(gap_max, 0)));
    u_bus.s_valid = 1;
    u_bus.s_sof   = sof;
    u_bus.s_eol   = eol;
    u_bus.s_data  = DW'($urandom);
    tick();
    u_bus.s_valid = 0;
  endtask

  // bad_kind: 1 = flip EOL at bad_at, 2 = inject SOF at bad_at. Stops before stop_at.
  task automatic send_frame(input int gap_max, input int bad_at, input int bad_kind,
                            input int stop_at);
    bit sof, eol;
    for (int p = 0; p < N && p != stop_at; p++) begin
      sof = (p == 0);
      eol = ((p % W) == W - 1);
      if (p == bad_at && bad_kind == 1) eol = !eol;
      if (p == bad_at && bad_kind == 2) sof = 1;
      send_beat(sof, eol, gap_max);
    end
  endtask

  task automatic pulse_start();
    start = 1;
    tick();
    start = 0;
    tick();
  endtask

  initial begin
    rst = 1; start = 0; fsr = 0;
    u_bus.s_valid = 0; u_bus.s_sof = 0; u_bus.s_eol = 0; u_bus.s_data = '0;
    model_reset();
    @(posedge clk);
    #1;
    rst = 0;
    idle(3);

    // Clean frame, back-to-back beats
    pulse_start();
    send_frame(0, -1, 0, -1);
    idle(3);

    // Start deferred while the draw stage reads the RAM
    fsr = 1;
    pulse_start();
    idle(20);
    fsr = 0;
    idle(3);

    // Garbage before SOF, then a frame with random gaps
    for (int i = 0; i < 10; i++) send_beat(1'b0, 1'($urandom), 1);
    send_frame(1, -1, 0, -1);
    idle(3);

    // Early EOL mid-frame, then a clean frame; err_sync must persist
    pulse_start();
    send_frame(2, 3 * W + 5, 1, -1);
    send_frame(1, -1, 0, -1);
    idle(3);

    // Reset mid-frame, then a fresh capture
    pulse_start();
    send_frame(0, -1, 0, 50);
    rst = 1;
    tick();
    rst = 0;
    idle(2);
    pulse_start();
    send_frame(1, -1, 0, -1);
    idle(3);

    // SOF injected mid-frame, then a clean frame
    pulse_start();
    send_frame(1, 2 * W + 7, 2, -1);
    send_frame(0, -1, 0, -1);
    idle(3);

    // EOL missing on the final pixel: error wins, no pic_done
    pulse_start();
    send_frame(0, N - 1, 1, -1);
    idle(4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
